cv32e40px_x_offload_tracker: RTL

Tracks every instruction offloaded over the CORE-V-XIF between issue acceptance and result retirement. Sits beside the ID/EX stage of the core: allocates issue IDs, sequences in-order commit/kill transactions, blocks issue on capacity, flags source-operand hazards against pending coprocessor writebacks, and arbitrates the shared register-file write port between the core's own writeback and coprocessor results.

---
 rtl/cv32e40px_x_offload_tracker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cv32e40px_x_offload_tracker.sv
// =============================================================================
// Module   : cv32e40px_x_offload_tracker
// Brief    : CORE-V-XIF offload tracker (ID allocation, commit/kill, hazards,
//            result/RF-port arbitration). Optional: CV32E40PX_X_RESULT_CHECK_EN.
// Revision : 1.0
// =============================================================================
`default_nettype none

module cv32e40px_x_offload_tracker #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    output logic [ID_WIDTH-1:0]                      issue_id_o,
    output logic                                     issue_full_o,
    input  logic                                     issue_accept_i,
    input  logic                                     issue_writeback_i,
    input  logic [4:0]                               issue_rd_i,
    input  logic [2:0][4:0]                          rs_addr_i,
    output logic [2:0]                               rs_hazard_o,
    input  logic                                     commit_i,
    input  logic                                     kill_i,
    output logic                                     commit_valid_o,
    output logic [ID_WIDTH-1:0]                      commit_id_o,
    output logic                                     commit_kill_o,
    input  logic                                     core_wb_valid_i,
    input  logic                                     result_valid_i,
    output logic                                     result_ready_o,
    input  logic [ID_WIDTH-1:0]                      result_id_i,
    input  logic                                     result_we_i,
    input  logic [4:0]                               result_rd_i,
    output logic                                     x_rf_we_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     proto_err_o
);

    localparam int                  c_DEPTH = 2**ID_WIDTH;
    localparam int                  c_CNT_W = $clog2(MAX_OUTSTANDING+1);
    localparam logic [c_CNT_W-1:0]  c_MAX   = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_ZERO  = '0;

    logic [c_DEPTH-1:0]   r_valid;
    logic [c_DEPTH-1:0]   r_committed;
    logic [c_DEPTH-1:0]   r_wb;
    logic [4:0]           r_rd [c_DEPTH];
    logic [ID_WIDTH-1:0]  r_alloc_ptr;
    logic [ID_WIDTH-1:0]  r_commit_ptr;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic                 r_commit_valid;
    logic                 r_commit_kill;
    logic [ID_WIDTH-1:0]  r_commit_id;

    logic                 w_full;
    logic                 w_issue_fire;
    logic                 w_cm_legal;
    logic                 w_kill_fire;
    logic                 w_commit_fire;
    logic                 w_res_fire;
    logic                 w_res_ok;
    logic                 w_res_free;
    logic                 w_res_dec;
    logic [2:0]           w_hazard;
    logic [4:0]           w_unused_rd;

    // The RF address travels outside this block; only kept to keep the port.
    assign w_unused_rd   = result_rd_i;

    assign w_full        = (r_outstanding == c_MAX) | r_valid[r_alloc_ptr];
    assign w_issue_fire  = issue_accept_i & ~w_full;

    assign w_cm_legal    = r_valid[r_commit_ptr] & ~r_committed[r_commit_ptr];
    assign w_kill_fire   = kill_i & w_cm_legal;
    assign w_commit_fire = commit_i & ~kill_i & w_cm_legal;

    assign w_res_fire    = result_valid_i & ~core_wb_valid_i;

`ifdef CV32E40PX_X_RESULT_CHECK_EN
    assign w_res_ok      = r_valid[result_id_i] & r_committed[result_id_i];
`else
    assign w_res_ok      = 1'b1;
`endif

    // Only a result landing on a live entry frees a slot; a same-cycle kill of
    // that entry must not be counted twice.
    assign w_res_free    = w_res_fire & w_res_ok & r_valid[result_id_i];
    assign w_res_dec     = w_res_free & ~(w_kill_fire & (result_id_i == r_commit_ptr));

    always_comb begin
        w_hazard = '0;
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < c_DEPTH; e++) begin
                w_hazard[k] = w_hazard[k] | (r_valid[e] & r_wb[e] &
                              (r_rd[e] == rs_addr_i[k]) & (rs_addr_i[k] != 5'd0));
            end
        end
    end

    // Issue is applied last so a fresh allocation wins over a stale result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_wb        <= '0;
            for (int e = 0; e < c_DEPTH; e++) begin
                r_rd[e] <= '0;
            end
        end else begin
            if (w_res_free) begin
                r_valid[result_id_i] <= 1'b0;
            end
            if (w_kill_fire) begin
                r_valid[r_commit_ptr] <= 1'b0;
            end
            if (w_commit_fire) begin
                r_committed[r_commit_ptr] <= 1'b1;
            end
            if (w_issue_fire) begin
                r_valid[r_alloc_ptr]     <= 1'b1;
                r_committed[r_alloc_ptr] <= 1'b0;
                r_wb[r_alloc_ptr]        <= issue_writeback_i;
                r_rd[r_alloc_ptr]        <= issue_rd_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc_ptr    <= '0;
            r_commit_ptr   <= '0;
            r_outstanding  <= '0;
            r_commit_valid <= 1'b0;
            r_commit_kill  <= 1'b0;
            r_commit_id    <= '0;
        end else begin
            if (w_issue_fire) begin
                r_alloc_ptr <= r_alloc_ptr + 1'b1;
            end
            if (w_kill_fire | w_commit_fire) begin
                r_commit_ptr <= r_commit_ptr + 1'b1;
            end
            r_outstanding  <= r_outstanding
                            + (w_issue_fire ? c_ONE : c_ZERO)
                            - (w_kill_fire  ? c_ONE : c_ZERO)
                            - (w_res_dec    ? c_ONE : c_ZERO);
            r_commit_valid <= w_kill_fire | w_commit_fire;
            r_commit_kill  <= w_kill_fire;
            r_commit_id    <= r_commit_ptr;
        end
    end

`ifdef CV32E40PX_X_RESULT_CHECK_EN
    logic r_proto_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if ((issue_accept_i & w_full) | (w_res_fire & ~w_res_ok)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err_o = r_proto_err;
`else
    assign proto_err_o = 1'b0;
`endif

    assign issue_id_o     = r_alloc_ptr;
    assign issue_full_o   = w_full;
    assign rs_hazard_o    = w_hazard;
    assign commit_valid_o = r_commit_valid;
    assign commit_id_o    = r_commit_id;
    assign commit_kill_o  = r_commit_kill;
    assign result_ready_o = ~core_wb_valid_i;
    assign x_rf_we_o      = w_res_fire & result_we_i & w_res_ok;
    assign outstanding_o  = r_outstanding;

endmodule

`default_nettype wire
